// File: rtl/bcd_digit_combiner_if.sv
// Digit-entry bus of the BCD tens/units combiner: digit strobes and abort in,
// combined value, result pulses and entry-progress echo out.
interface bcd_digit_combiner_if;
    logic       clear;
    logic [3:0] digit_in;
    logic       digit_valid;
    logic [5:0] value;
    logic       value_valid;
    logic       error;
    logic       awaiting_units;
    logic [3:0] pending_tens;

    modport master (
        output clear,
        output digit_in,
        output digit_valid,
        input  value,
        input  value_valid,
        input  error,
        input  awaiting_units,
        input  pending_tens
    );

    modport slave (
        input  clear,
        input  digit_in,
        input  digit_valid,
        output value,
        output value_valid,
        output error,
        output awaiting_units,
        output pending_tens
    );
endinterface

// File: rtl/bcd_digit_combiner.sv
// Combines a tens then a units BCD strobe into a range-checked 6-bit value.
// Optional entry timeout compiled in with `define BCD_COMBINER_TIMEOUT_EN.
module bcd_digit_combiner #(
    parameter int unsigned MAX_VALUE      = 59,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input logic                clk,
    input logic                rst_n,
    bcd_digit_combiner_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE       = 1'b0,
        WAIT_UNITS = 1'b1
    } state_t;

    localparam logic [6:0] MAX_V = 7'(MAX_VALUE);

    function automatic logic is_bcd(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

    // tens*10 + units, built from shifts so no multiplier is inferred
    function automatic logic [6:0] combine(input logic [3:0] t, input logic [3:0] u);
        logic [6:0] t7;
        t7 = {3'b000, t};
        return (t7 << 3) + (t7 << 1) + {3'b000, u};
    endfunction

    state_t     state_r, state_nxt_s;
    logic [3:0] pending_r, pending_nxt_s;
    logic [5:0] value_r, value_nxt_s;
    logic       value_valid_r, value_valid_nxt_s;
    logic       error_r, error_nxt_s;
    logic [6:0] sum_s;
    logic       timeout_s;
    logic       unused_cfg_s;

    assign sum_s        = combine(pending_r, bus.digit_in);
    assign unused_cfg_s = (TIMEOUT_CYCLES >= 32'd2);

`ifdef BCD_COMBINER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;

    // A strobe or clear in the limit cycle takes precedence over the timeout
    assign timeout_s = (state_r == WAIT_UNITS) && (cnt_r == CNT_LIMIT) &&
                       !bus.digit_valid && !bus.clear;

    // Counter advances only while waiting for units with no strobe; otherwise held at 0
    always_comb begin
        cnt_nxt_s = CNT_ZERO;
        if ((state_r == WAIT_UNITS) && !bus.digit_valid && !bus.clear && !timeout_s) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_nxt_s = CNT_ZERO;
        end
    end

    // Timeout counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and next-output decode
    always_comb begin
        state_nxt_s       = state_r;
        pending_nxt_s     = pending_r;
        value_nxt_s       = value_r;
        value_valid_nxt_s = 1'b0;
        error_nxt_s       = 1'b0;

        if (bus.clear) begin
            state_nxt_s   = IDLE;
            pending_nxt_s = 4'd0;
        end else if (bus.digit_valid) begin
            case (state_r)
                IDLE: begin
                    if (is_bcd(bus.digit_in)) begin
                        pending_nxt_s = bus.digit_in;
                        state_nxt_s   = WAIT_UNITS;
                    end else begin
                        error_nxt_s = 1'b1;
                    end
                end
                WAIT_UNITS: begin
                    state_nxt_s   = IDLE;
                    pending_nxt_s = 4'd0;
                    if (is_bcd(bus.digit_in) && (sum_s <= MAX_V)) begin
                        value_nxt_s       = sum_s[5:0];
                        value_valid_nxt_s = 1'b1;
                    end else begin
                        error_nxt_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s   = IDLE;
                    pending_nxt_s = 4'd0;
                end
            endcase
        end else if (timeout_s) begin
            state_nxt_s   = IDLE;
            pending_nxt_s = 4'd0;
            error_nxt_s   = 1'b1;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            pending_r     <= 4'd0;
            value_r       <= 6'd0;
            value_valid_r <= 1'b0;
            error_r       <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            pending_r     <= pending_nxt_s;
            value_r       <= value_nxt_s;
            value_valid_r <= value_valid_nxt_s;
            error_r       <= error_nxt_s;
        end
    end

    assign bus.value          = value_r;
    assign bus.value_valid    = value_valid_r;
    assign bus.error          = error_r;
    assign bus.awaiting_units = (state_r == WAIT_UNITS);
    assign bus.pending_tens   = pending_r;

endmodule

// File: tb/tb_bcd_digit_combiner.sv
// Directed bench: one minutes-range (59) and one hours-range (23) combiner
// share the same digit stream; each is checked against hand-computed values.
module tb_bcd_digit_combiner;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [3:0] digit_in;
    logic       digit_valid;
    int         n_checks;
    int         n_errors;
    int         aw_cycles;

    bcd_digit_combiner_if b59 ();
    bcd_digit_combiner_if b23 ();

    assign b59.clear       = clear;
    assign b59.digit_in    = digit_in;
    assign b59.digit_valid = digit_valid;
    assign b23.clear       = clear;
    assign b23.digit_in    = digit_in;
    assign b23.digit_valid = digit_valid;

    bcd_digit_combiner #(.MAX_VALUE(59), .TIMEOUT_CYCLES(8)) dut59 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b59)
    );

    bcd_digit_combiner #(.MAX_VALUE(23), .TIMEOUT_CYCLES(8)) dut23 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b23)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one cycle of input, let the edge sample it, settle 1 time unit past it
    task automatic cyc(input logic v, input logic [3:0] d, input logic c);
        digit_valid = v;
        digit_in    = d;
        clear       = c;
        @(posedge clk);
        #1;
        digit_valid = 1'b0;
        digit_in    = 4'd0;
        clear       = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        clear       = 1'b0;
        digit_in    = 4'd0;
        digit_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_value",   8'(b59.value), 8'd0);
        check("rst_vv",      8'(b59.value_valid), 8'd0);
        check("rst_err",     8'(b59.error), 8'd0);
        check("rst_aw",      8'(b59.awaiting_units), 8'd0);
        check("rst_pend",    8'(b59.pending_tens), 8'd0);
        rst_n = 1'b1;
        idle(1);

        // Normal entry 4,7
        cyc(1'b1, 4'd4, 1'b0);
        check("n_aw",   8'(b59.awaiting_units), 8'd1);
        check("n_pend", 8'(b59.pending_tens), 8'd4);
        cyc(1'b1, 4'd7, 1'b0);
        check("n_value", 8'(b59.value), 8'd47);
        check("n_vv",    8'(b59.value_valid), 8'd1);
        check("n_err",   8'(b59.error), 8'd0);
        check("n_aw0",   8'(b59.awaiting_units), 8'd0);
        check("n_pend0", 8'(b59.pending_tens), 8'd0);
        check("h47_err", 8'(b23.error), 8'd1);
        check("h47_val", 8'(b23.value), 8'd0);
        idle(1);
        check("n_vv_low", 8'(b59.value_valid), 8'd0);
        check("h_err_low", 8'(b23.error), 8'd0);

        // Range limit on the hours instance
        cyc(1'b1, 4'd1, 1'b0);
        cyc(1'b1, 4'd2, 1'b0);
        check("h12_val", 8'(b23.value), 8'd12);
        check("h12_vv",  8'(b23.value_valid), 8'd1);
        cyc(1'b1, 4'd2, 1'b0);
        cyc(1'b1, 4'd5, 1'b0);
        check("h25_err", 8'(b23.error), 8'd1);
        check("h25_val", 8'(b23.value), 8'd12);
        check("h25_vv",  8'(b23.value_valid), 8'd0);
        check("m25_val", 8'(b59.value), 8'd25);
        idle(1);
        check("h25_err_low", 8'(b23.error), 8'd0);
        cyc(1'b1, 4'd2, 1'b0);
        cyc(1'b1, 4'd3, 1'b0);
        check("h23_val", 8'(b23.value), 8'd23);
        check("h23_vv",  8'(b23.value_valid), 8'd1);
        check("h23_err", 8'(b23.error), 8'd0);
        idle(1);

        // Bad digits
        cyc(1'b1, 4'hA, 1'b0);
        check("badA_err", 8'(b59.error), 8'd1);
        check("badA_aw",  8'(b59.awaiting_units), 8'd0);
        idle(1);
        check("badA_err_low", 8'(b59.error), 8'd0);
        cyc(1'b1, 4'd1, 1'b0);
        check("bad1_aw", 8'(b59.awaiting_units), 8'd1);
        cyc(1'b1, 4'hF, 1'b0);
        check("badF_err", 8'(b59.error), 8'd1);
        check("badF_aw",  8'(b59.awaiting_units), 8'd0);
        check("badF_val", 8'(b59.value), 8'd23);
        check("badF_vv",  8'(b59.value_valid), 8'd0);
        idle(1);

        // Clear beats a same-cycle strobe, then back-to-back entries
        cyc(1'b1, 4'd5, 1'b0);
        cyc(1'b1, 4'd9, 1'b1);
        check("clr_aw",   8'(b59.awaiting_units), 8'd0);
        check("clr_pend", 8'(b59.pending_tens), 8'd0);
        check("clr_vv",   8'(b59.value_valid), 8'd0);
        check("clr_err",  8'(b59.error), 8'd0);
        check("clr_val",  8'(b59.value), 8'd23);
        cyc(1'b1, 4'd0, 1'b0);
        check("b2b_aw", 8'(b59.awaiting_units), 8'd1);
        cyc(1'b1, 4'd9, 1'b0);
        check("b2b_v9",  8'(b59.value), 8'd9);
        check("b2b_vv9", 8'(b59.value_valid), 8'd1);
        cyc(1'b1, 4'd3, 1'b0);
        check("b2b_gap_vv", 8'(b59.value_valid), 8'd0);
        check("b2b_pend3",  8'(b59.pending_tens), 8'd3);
        cyc(1'b1, 4'd8, 1'b0);
        check("b2b_v38",  8'(b59.value), 8'd38);
        check("b2b_vv38", 8'(b59.value_valid), 8'd1);
        check("h38_err",  8'(b23.error), 8'd1);
        check("h38_val",  8'(b23.value), 8'd9);
        idle(1);

`ifdef BCD_COMBINER_TIMEOUT_EN
        // Timeout fires on the 8th edge after the tens strobe
        cyc(1'b1, 4'd3, 1'b0);
        aw_cycles = 0;
        for (int i = 0; i < 7; i++) begin
            idle(1);
            if (b59.awaiting_units === 1'b1 && b59.error === 1'b0) aw_cycles++;
        end
        check("to_hold", 8'(aw_cycles), 8'd7);
        idle(1);
        check("to_err",  8'(b59.error), 8'd1);
        check("to_pend", 8'(b59.pending_tens), 8'd0);
        check("to_aw",   8'(b59.awaiting_units), 8'd0);
        idle(1);
        check("to_err_low", 8'(b59.error), 8'd0);
        cyc(1'b1, 4'd3, 1'b0);
        idle(7);
        cyc(1'b1, 4'd6, 1'b0);
        check("to_win_val", 8'(b59.value), 8'd36);
        check("to_win_vv",  8'(b59.value_valid), 8'd1);
        check("to_win_err", 8'(b59.error), 8'd0);
        idle(1);
`else
        // Without the timeout the entry waits indefinitely
        cyc(1'b1, 4'd3, 1'b0);
        aw_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            idle(1);
            if (b59.awaiting_units === 1'b1 && b59.error === 1'b0) aw_cycles++;
        end
        check("nto_hold", 8'(aw_cycles), 8'd100);
        cyc(1'b0, 4'd0, 1'b1);
        check("nto_clr_aw", 8'(b59.awaiting_units), 8'd0);
`endif

        // Asynchronous reset mid-entry
        cyc(1'b1, 4'd5, 1'b0);
        check("ar_aw_pre", 8'(b59.awaiting_units), 8'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_aw",   8'(b59.awaiting_units), 8'd0);
        check("ar_pend", 8'(b59.pending_tens), 8'd0);
        check("ar_val",  8'(b59.value), 8'd0);
        check("ar_vv",   8'(b59.value_valid), 8'd0);
        check("ar_err",  8'(b59.error), 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 4'd1, 1'b0);
        cyc(1'b1, 4'd2, 1'b0);
        check("ar_v12",  8'(b59.value), 8'd12);
        check("ar_vv12", 8'(b59.value_valid), 8'd1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_digit_combiner.md
# bcd_digit_combiner

Sequential BCD-to-binary entry block for the alarm clock's time-setting path. It accepts a tens digit and then a units digit as two separate 4-bit BCD strobes, for example from the keypad or the set buttons. It range-checks the pair and emits the combined 6-bit binary value as a one-cycle result. It performs the inverse of the tens/units split that feeds the display, and its `value` output is directly compatible with that splitter's 6-bit input.

## Interface
- `MAX_VALUE`, default 59: largest accepted combined value; 23 for hours, 59 for minutes/seconds. Legal range 0..63.
- `TIMEOUT_CYCLES`, default 50_000_000: cycles allowed between the tens digit and the units digit. Used only when timeout is compiled in. Must be ≥2.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous abort of any entry in progress.
- `digit_in` input 4: BCD digit, sampled when `digit_valid`=1.
- `digit_valid` input 1: one-cycle digit strobe.
- `value` output 6: last successfully combined binary value. Holds until the next success.
- `value_valid` output 1: one-cycle pulse when `value` is updated.
- `error` output 1: one-cycle pulse on a bad digit, an out-of-range result, or a timeout.
- `awaiting_units` output 1: high while the tens digit is held.
- `pending_tens` output 4: the held tens digit, for display echo. It is 0 when not awaiting.

## Operation
- Two states: `IDLE` (waiting for tens) and `WAIT_UNITS`.
- **IDLE, valid digit** (`digit_valid`=1 and `digit_in`≤9):
  - `pending_tens`←`digit_in`
  - move to `WAIT_UNITS`
  - timeout counter←0
- **IDLE, bad digit** (`digit_valid`=1 and `digit_in`>9): `error` pulse, stay in `IDLE`.
- **WAIT_UNITS, valid digit**:
  - Compute `sum = (pending_tens<<3) + (pending_tens<<1) + digit_in` at 7-bit width; maximum is 99.
  - If `sum`≤`MAX_VALUE`: `value`←`sum[5:0]` and pulse `value_valid`.
  - Otherwise: pulse `error` and leave `value` unchanged.
  - Either way: return to `IDLE` and set `pending_tens`←0.
- **WAIT_UNITS, bad digit** (`digit_in`>9): `error` pulse, return to `IDLE`, `pending_tens`←0.
- **`clear`** has priority over `digit_valid` in any state:
  - go to `IDLE` and set `pending_tens`←0
  - no `error` pulse
  - `value` is unchanged
- `value_valid` and `error` are never high in the same cycle.
- `awaiting_units` equals (state == `WAIT_UNITS`).

## Timing
- **Reset values** (`rst_n`=0):
  - state `IDLE`
  - `value`=0, `value_valid`=0, `error`=0
  - `awaiting_units`=0, `pending_tens`=0
  - timeout counter=0
- **Reset mid-entry:** the entry is discarded and no pulse is produced.
- **Latency:** `value_valid`/`error` are registered. They are high during the cycle following the edge that sampled the deciding digit, and low the cycle after.
- **Back-to-back entries:** a digit strobed in the same cycle that `value_valid`/`error` is high is accepted as a new tens digit, because the state is already `IDLE`. Entries can arrive every cycle, with one result per two digits.
- **`awaiting_units`:** rises the cycle after the tens strobe. Falls the cycle after the units strobe, `clear`, or timeout.
- **`digit_valid` held high:** sampled every cycle; each high cycle is a separate digit.

## Configuration
- **`BCD_COMBINER_TIMEOUT_EN` defined:**
  - In `WAIT_UNITS`, the counter increments each cycle with no `digit_valid`/`clear`.
  - The counter is ⌈log2(`TIMEOUT_CYCLES`)⌉ bits wide and held at 0 in `IDLE`.
  - When the counter equals `TIMEOUT_CYCLES`-1 with no strobe that cycle: `error` pulse, `pending_tens`←0, go to `IDLE`.
  - A `digit_valid` arriving in the cycle the counter hits the limit wins; it is processed normally with no timeout.
- **Undefined:** no counter is instantiated, and `WAIT_UNITS` waits indefinitely.

## Test plan
- **Normal entry:** reset, `MAX_VALUE`=59; strobe 4, then 7 on consecutive cycles.
  - `awaiting_units`=1 with `pending_tens`=4 between strobes.
  - Then `value`=47, `value_valid` high for exactly 1 cycle, `error`=0.
- **Range fail:** `MAX_VALUE`=23, prior `value`=12; strobe 2, then 5.
  - `error` 1-cycle pulse, `value` stays 12, `value_valid` stays 0.
  - Also strobe 2, then 3 → `value`=23.
- **Bad digit:** strobe 4'hA in `IDLE` → `error` pulse, `awaiting_units`=0. Strobe 1, then 4'hF → `error` pulse, back to `IDLE`, `value` unchanged.
- **Clear and back-to-back:**
  - Strobe 5, assert `clear` with strobe 9 in the same cycle → `IDLE`, no pulses.
  - Then strobes 0, 9, 3, 8 on four consecutive cycles → `value`=9 pulse, then `value`=38 pulse, two cycles apart.
- **Timeout** (`BCD_COMBINER_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8):
  - Strobe 3 with no further strobes → `error` pulse 8 cycles after the tens strobe edge, `pending_tens`=0.
  - Repeat with a units strobe 6 in the limit cycle → `value`=36, no `error`.
  - Without the macro, the same idle stimulus keeps `awaiting_units`=1 for ≥100 cycles.
- **Async reset mid-entry:** strobe 5, drop `rst_n` between clock edges → outputs are 0 immediately. After release, strobe 1, then 2 → `value`=12.
